// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, default sizes and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int DEFAULT_NREQ         = 2;
    localparam int DEFAULT_DBIT         = 8;
    localparam int DEFAULT_HOLD_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } arb_state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int DBIT = DEFAULT_DBIT
);

    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] din;
    logic [NREQ-1:0]      last;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_data;
    logic                 tx_done_tick;
    logic                 busy;
    logic                 timeout_err;

    // master = requesters plus the transmitter; slave = the arbiter itself
    modport master (
        output req, din, last, tx_done_tick,
        input  ack, grant, tx_start, tx_data, busy, timeout_err
    );

    modport slave (
        input  req, din, last, tx_done_tick,
        output ack, grant, tx_start, tx_data, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester after ptr (modulo NREQ) that is asserting req.
module rr_priority_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [PW-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = ptr;
        // Walk ptr+1, ptr+2, ... wrapping at NREQ; ptr itself is visited last.
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!valid && req[cand]) begin
                winner[cand] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ requesters, round-robin, packet-atomic.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ         = DEFAULT_NREQ,
    parameter int DBIT         = DEFAULT_DBIT,
    parameter int HOLD_TIMEOUT = DEFAULT_HOLD_TIMEOUT
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);

    arb_state_e      state_q, state_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic            tx_start_q, tx_start_nxt;
    logic [DBIT-1:0] tx_data_q, tx_data_nxt;
    logic            lastflag_q, lastflag_nxt;
    logic            timeout_q, timeout_nxt;
    logic            busy_q;
    logic [PW-1:0]   ptr_q, ptr_nxt;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_nxt;

    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [DBIT-1:0] pick_data, own_data;
    logic            pick_last, own_req, own_last, ack_pending;
    logic [PW-1:0]   own_idx;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick),
        .valid  (pick_valid)
    );

    // One-hot selection of the candidate's and the owner's byte and index.
    always_comb begin
        pick_data = '0;
        own_data  = '0;
        own_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_data = bus.din[i*DBIT +: DBIT];
            end
            if (grant_q[i]) begin
                own_data = bus.din[i*DBIT +: DBIT];
                own_idx  = PW'(i);
            end
        end
    end

    assign pick_last   = |(pick & bus.last);
    assign own_req     = |(grant_q & bus.req);
    assign own_last    = |(grant_q & bus.last);
    assign ack_pending = |ack_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt    = state_q;
        grant_nxt    = grant_q;
        ack_nxt      = '0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data_q;
        lastflag_nxt = lastflag_q;
        ptr_nxt      = ptr_q;
        hold_cnt_nxt = hold_cnt_q;
        timeout_nxt  = timeout_q;

        case (state_q)
            IDLE: begin
                // During the ack cycle req still shows the byte just sent; ignore it.
                if (pick_valid && !ack_pending) begin
                    grant_nxt    = pick;
                    tx_data_nxt  = pick_data;
                    lastflag_nxt = pick_last;
                    tx_start_nxt = 1'b1;
                    state_nxt    = WAIT;
                end
            end

            WAIT: begin
                // A done tick alongside tx_start belongs to nothing we started.
                if (bus.tx_done_tick && !tx_start_q) begin
                    ack_nxt = grant_q;
                    if (lastflag_q) begin
                        ptr_nxt   = own_idx;
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        hold_cnt_nxt = '0;
                        state_nxt    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (own_req && !ack_pending) begin
                    tx_data_nxt  = own_data;
                    lastflag_nxt = own_last;
                    tx_start_nxt = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = WAIT;
                end else if (hold_cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
                    timeout_nxt  = 1'b1;
                    ptr_nxt      = own_idx;
                    grant_nxt    = '0;
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            lastflag_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= PW'(NREQ - 1);
            hold_cnt_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            state_q    <= state_nxt;
            grant_q    <= grant_nxt;
            ack_q      <= ack_nxt;
            tx_start_q <= tx_start_nxt;
            tx_data_q  <= tx_data_nxt;
            lastflag_q <= lastflag_nxt;
            timeout_q  <= timeout_nxt;
            busy_q     <= (state_nxt != IDLE);
            ptr_q      <= ptr_nxt;
            hold_cnt_q <= hold_cnt_nxt;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester agents, transmitter model and a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int DBIT = 8;
    localparam int HT   = 15;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .HOLD_TIMEOUT(HT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    item_t            rq[NREQ][$];
    logic [7:0]       started[$];
    logic [NREQ-1:0]  start_grant[$];
    int               start_gap[$];
    logic [7:0]       exp_bytes[$];
    int               exp_owner[$];
    int               ack_cnt      = 0;
    int               last_ack_cyc = 0;
    int               fixed_len    = 6;
    int               model_ptr    = NREQ - 1;
    logic [7:0]       tx_hold;
    logic [NREQ-1:0]  tx_grant;
    int               tx_cnt    = 0;
    logic             tx_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Requesters: present the queue head, pop it on ack, drop req when empty.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) rq[i].delete();
            bus.req  = '0;
            bus.din  = '0;
            bus.last = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    bus.req[i]              = 1'b1;
                    bus.din[i*DBIT +: DBIT] = rq[i][0].data;
                    bus.last[i]             = rq[i][0].last;
                end else begin
                    bus.req[i]              = 1'b0;
                    bus.din[i*DBIT +: DBIT] = '0;
                    bus.last[i]             = 1'b0;
                end
            end
        end
    end

    // Transmitter: done tick tx_cnt cycles after start; logs bytes, owners and gaps.
    always @(negedge clk) begin
        if (!reset) begin
            tx_cnt           = 0;
            tx_active        = 1'b0;
            bus.tx_done_tick = 1'b0;
        end else begin
            bus.tx_done_tick = 1'b0;
            if (bus.tx_start) begin
                started.push_back(bus.tx_data);
                start_grant.push_back(bus.grant);
                start_gap.push_back(cyc - last_ack_cyc);
                tx_hold   = bus.tx_data;
                tx_grant  = bus.grant;
                tx_cnt    = (fixed_len > 0) ? fixed_len : int'($urandom_range(12, 2));
                tx_active = 1'b1;
            end else if (tx_active) begin
                check("tx_data_stable", bus.tx_data, tx_hold);
                check("grant_stable", bus.grant, tx_grant);
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.tx_done_tick = 1'b1;
                    tx_active        = 1'b0;
                end
            end
            if (bus.ack != '0) begin
                ack_cnt      += $countones(bus.ack);
                last_ack_cyc  = cyc;
            end
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        rq[r].push_back(it);
    endtask

    task automatic clear_obs();
        started.delete();
        start_grant.delete();
        start_gap.delete();
        ack_cnt = 0;
    endtask

    // Packet-level round robin: every queued requester is pending at each arbitration.
    task automatic plan();
        item_t cp[NREQ][$];
        item_t it;
        int    i;
        bit    found;
        exp_bytes.delete();
        exp_owner.delete();
        for (int r = 0; r < NREQ; r++) cp[r] = rq[r];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ && !found; k++) begin
                i = (model_ptr + k) % NREQ;
                if (cp[i].size() > 0) begin
                    found = 1'b1;
                    do begin
                        it = cp[i].pop_front();
                        exp_bytes.push_back(it.data);
                        exp_owner.push_back(i);
                    end while (!it.last && cp[i].size() > 0);
                    model_ptr = i;
                end
            end
        end
    endtask

    function automatic bit queues_empty();
        for (int r = 0; r < NREQ; r++) if (rq[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            tick();
            if (queues_empty() && !bus.busy && !tx_active && bus.ack == '0) done = 1'b1;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic verify(input string tag);
        check({tag, "_count"}, started.size(), exp_bytes.size());
        check({tag, "_acks"}, ack_cnt, exp_bytes.size());
        for (int j = 0; j < exp_bytes.size() && j < started.size(); j++) begin
            check($sformatf("%s_byte%0d", tag, j), started[j], exp_bytes[j]);
            check($sformatf("%s_owner%0d", tag, j), start_grant[j], 1 << exp_owner[j]);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset     = 1'b1;
        model_ptr = NREQ - 1;
        tick();
        clear_obs();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_timeout", bus.timeout_err, 0);
        reset = 1'b1;
        tick();

        // Single byte with a 160-cycle transmitter
        fixed_len = 160;
        clear_obs();
        push(0, 8'hA5, 1'b1);
        plan();
        tick();
        check("single_no_early_start", bus.tx_start, 0);
        tick();
        check("single_tx_start", bus.tx_start, 1);
        check("single_tx_data", bus.tx_data, 8'hA5);
        check("single_grant", bus.grant, 2'b01);
        check("single_busy", bus.busy, 1);
        tick();
        check("single_start_one_cycle", bus.tx_start, 0);
        n = 1;
        while (bus.ack == '0 && n < 400) begin
            tick();
            n++;
        end
        check("single_ack_latency", n, 161);
        check("single_ack", bus.ack, 2'b01);
        check("single_grant_free", bus.grant, 0);
        check("single_busy_low", bus.busy, 0);
        tick();
        check("single_ack_one_cycle", bus.ack, 0);
        wait_done("single", 50);
        verify("single");

        // Round robin with two single-byte streams
        pulse_reset();
        fixed_len = 8;
        push(0, 8'h11, 1'b1); push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1); push(1, 8'h22, 1'b1);
        plan();
        wait_done("rr", 300);
        verify("rr");

        // Packet atomicity: a 3-byte packet is never interleaved
        clear_obs();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
        push(1, 8'hFF, 1'b1);
        plan();
        wait_done("pkt", 300);
        verify("pkt");

        // Hold timeout: owner abandons its packet while requester 1 waits
        clear_obs();
        fixed_len = 6;
        push(0, 8'hAA, 1'b0);
        push(1, 8'hBB, 1'b1);
        plan();
        n = 0;
        while (bus.ack == '0 && n < 100) begin
            tick();
            n++;
        end
        check("to_ack", bus.ack, 2'b01);
        check("to_grant_kept", bus.grant, 2'b01);
        check("to_busy_hold", bus.busy, 1);
        repeat (14) tick();
        check("to_not_yet", bus.timeout_err, 0);
        check("to_grant_still", bus.grant, 2'b01);
        tick();
        check("to_err", bus.timeout_err, 1);
        check("to_grant_free", bus.grant, 0);
        check("to_no_ack", bus.ack, 0);
        tick();
        check("to_next_grant", bus.grant, 2'b10);
        check("to_next_start", bus.tx_start, 1);
        check("to_next_data", bus.tx_data, 8'hBB);
        wait_done("to", 100);
        verify("to");
        check("to_sticky", bus.timeout_err, 1);

        // Reset in the middle of WAIT
        clear_obs();
        fixed_len = 20;
        push(0, 8'hC3, 1'b1);
        n = 0;
        while (!bus.tx_start && n < 20) begin
            tick();
            n++;
        end
        check("mid_start_seen", bus.tx_start, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("mid_grant", bus.grant, 0);
        check("mid_tx_start", bus.tx_start, 0);
        check("mid_tx_data", bus.tx_data, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_timeout", bus.timeout_err, 0);
        check("mid_ack", bus.ack, 0);
        tick();
        reset     = 1'b1;
        model_ptr = NREQ - 1;
        clear_obs();
        push(1, 8'hD4, 1'b1);
        plan();
        tick();
        check("mid_no_grant_yet", bus.grant, 0);
        tick();
        check("mid_grant_req1", bus.grant, 2'b10);
        wait_done("mid", 100);
        verify("mid");

        // Back-to-back single-byte packets from requester 0
        clear_obs();
        fixed_len = 4;
        for (int b = 0; b < 50; b++) push(0, 8'($urandom), 1'b1);
        plan();
        wait_done("b2b", 1000);
        verify("b2b");
        for (int j = 1; j < start_gap.size(); j++) check($sformatf("b2b_gap%0d", j), start_gap[j], 2);

        // Randomised packets with random transmitter latency
        fixed_len = 0;
        for (int round = 0; round < 3; round++) begin
            clear_obs();
            for (int r = 0; r < NREQ; r++) begin
                int npk;
                npk = int'($urandom_range(4, 1));
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = int'($urandom_range(3, 1));
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                end
            end
            plan();
            wait_done($sformatf("rnd%0d", round), 2000);
            verify($sformatf("rnd%0d", round));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ requesters (e.g. ALU result path, status/echo path).
- Grants the transmitter round-robin and captures the winner's byte.
- Issues a one-cycle tx_start, waits for tx_done_tick, then acknowledges the requester.
- Supports multi-byte packets: grant is held until a byte flagged "last" completes, so packets never interleave on the line.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DBIT, 8, data bits per byte; must match the transmitter's DBIT.
- HOLD_TIMEOUT, 1023, clk cycles a granted requester may drop req mid-packet before the grant is forcibly released.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester byte-valid; held high until the matching ack.
- din  in  NREQ*DBIT  flattened bytes; requester i uses bits [i*DBIT +: DBIT].
- last  in  NREQ  per-requester end-of-packet flag, qualified by req.
- ack  out  NREQ  one-cycle pulse: requester's byte has been fully sent.
- grant  out  NREQ  one-hot current owner; 0 when free.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DBIT  byte to the transmitter; stable from the tx_start cycle until tx_done_tick.
- tx_done_tick  in  1  transmitter completion pulse.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky; set on HOLD_TIMEOUT expiry, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, ack=0, tx_start=0, tx_data=0, busy=0, timeout_err=0, hold counter=0.
  - rr pointer=NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - If any req is high, the winner is the first requester searching ptr+1, ptr+2, … modulo NREQ.
  - At that edge: grant=onehot(winner), tx_data=din[winner], lastflag=last[winner], tx_start=1 next cycle, state→WAIT.
  - Latency: req high at edge N gives tx_start high in cycle N+1.
- WAIT:
  - tx_start is high only in the first cycle of WAIT; tx_data is held.
  - On tx_done_tick: ack[winner]=1 for exactly one cycle. Then:
    - if lastflag=1: ptr=winner, grant=0, state→IDLE.
    - if lastflag=0: state→HOLD.
  - tx_done_tick on the same cycle as tx_start is ignored; the transmitter cannot complete in 1 cycle.
- HOLD (grant retained, mid-packet):
  - Granted req high → capture din/last of the owner, tx_start pulse next cycle, state→WAIT, hold counter cleared.
  - Requests from other requesters are ignored while in HOLD.
  - Granted req low → hold counter increments each cycle.
  - Counter reaching HOLD_TIMEOUT → timeout_err=1, ptr=owner, grant=0, state→IDLE. No ack is issued.
- ack timing: the requester must drop or replace req/din/last on the cycle after ack. A req still high in that cycle is treated as the next byte; in IDLE the arbiter re-arbitrates without re-granting the same requester if others are pending.
- Round-robin fairness: with all requesters continuously presenting single-byte packets, grants rotate 0,1,…,NREQ-1,0.
- Mid-operation reset forces IDLE immediately and drops tx_start. The transmitter owns its own reset, and the system asserts both resets together.
- Simultaneous events: ack and a new IDLE grant never occur on the same cycle, so one idle cycle exists between packets.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'b00, WAIT=2'b01, HOLD=2'b10.
  - Default NREQ/DBIT constants, used together with the transmitter's DBIT.
- One natural sub-module: rr_priority_pick. Combinational, takes req and ptr, returns a one-hot winner and a valid flag; reusable for other shared resources.
- Counters and FSM stay in the top module.

Test Plan:
- Single byte: req[0]=1, din0=8'hA5, last0=1.
  - tx_start pulses 1 cycle after the req edge with tx_data=8'hA5.
  - Model tx_done after 160 cycles → ack[0] pulses once, grant→0, busy→0.
- Round-robin: req[0]=req[1]=1 continuously, single-byte packets (8'h11 / 8'h22).
  - tx_data sequence 8'h11, 8'h22, 8'h11, 8'h22; no requester is granted twice in a row.
- Packet atomicity: req0 sends 3-byte packet 8'h01, 8'h02, 8'h03 (last on 3rd) while req1 is held high with 8'hFF.
  - Transmitted order 01, 02, 03, FF; grant[0] held throughout the packet.
- Timeout (HOLD_TIMEOUT=15 for sim): req0 sends one byte with last=0, then drops req.
  - 15 cycles after ack, timeout_err=1 and grant=0.
  - Pending req1 is then served.
- Reset mid-WAIT: assert reset=0 two cycles after tx_start.
  - All outputs return to reset values immediately.
  - After release with req[1]=1 only, grant=2'b10 on the next edge.
- Back-to-back: req[0] held with a new byte the cycle after ack.
  - One IDLE cycle, then a new tx_start; ack count equals tx_start count over 50 bytes.
